// File: rtl/sideband_pkg.sv
// Shared limits and parameter checks for the sideband retimer slice.
package sideband_pkg;

    localparam int unsigned STAGES_MAX   = 4;
    localparam int unsigned CHANNELS_MAX = 32;

    function automatic bit params_ok(input int unsigned channels, input int unsigned stages);
        return (channels >= 1) && (channels <= CHANNELS_MAX) && (stages <= STAGES_MAX);
    endfunction

endpackage

// File: rtl/sideband_edge_latch.sv
// Per-channel edge detector with a pending flag and a sticky lost-event flag.
module sideband_edge_latch (
    input  logic clock,
    input  logic reset,
    input  logic i_d,
    input  logic i_ack,
    output logic o_pending,
    output logic o_overflow
);

    logic r_prev;
    logic r_pending;
    logic r_overflow;
    logic w_rise;

    assign w_rise = i_d & ~r_prev;

    // A new rise always wins over a same-cycle ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev     <= 1'b0;
            r_pending  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_prev <= i_d;
            if (w_rise) begin
                r_pending <= 1'b1;
            end else if (i_ack) begin
                r_pending <= 1'b0;
            end
            if (w_rise && r_pending && !i_ack) begin
                r_overflow <= 1'b1;
            end else if (i_ack) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_pending  = r_pending;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/sideband_retimer.sv
// Multi-channel sideband retimer: fixed-depth delay per channel, then either
// a plain level output or an edge-captured pending flag with overflow.
module sideband_retimer
    import sideband_pkg::*;
#(
    parameter int unsigned          CHANNELS  = 6,
    parameter int unsigned          STAGES    = 2,
    parameter logic [CHANNELS-1:0]  EDGE_MASK = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in_sig,
    input  logic [CHANNELS-1:0] ack,
    output logic [CHANNELS-1:0] out_sig,
    output logic [CHANNELS-1:0] overflow
);

    if (!params_ok(CHANNELS, STAGES)) begin : g_param_check
        $error("sideband_retimer: CHANNELS must be 1..%0d and STAGES 0..%0d",
               CHANNELS_MAX, STAGES_MAX);
    end

    logic [CHANNELS-1:0] w_d;

    if (STAGES == 0) begin : g_bypass
        assign w_d = in_sig;
    end else begin : g_pipe
        logic [CHANNELS-1:0] r_stage [STAGES];

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                for (int k = 0; k < int'(STAGES); k++) begin
                    r_stage[k] <= '0;
                end
            end else begin
                r_stage[0] <= in_sig;
                for (int k = 1; k < int'(STAGES); k++) begin
                    r_stage[k] <= r_stage[k-1];
                end
            end
        end

        assign w_d = r_stage[STAGES-1];
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        if (EDGE_MASK[i]) begin : g_edge
            sideband_edge_latch u_latch (
                .clock      (clock),
                .reset      (reset),
                .i_d        (w_d[i]),
                .i_ack      (ack[i]),
                .o_pending  (out_sig[i]),
                .o_overflow (overflow[i])
            );
        end else begin : g_level
            assign out_sig[i]  = w_d[i];
            assign overflow[i] = 1'b0;
        end
    end

    // Level-only, zero-stage builds never read clock, reset or ack.
    logic w_unused;
    assign w_unused = ^{clock, reset, ack};

endmodule

// File: tb/tb_sideband_retimer.sv
// Directed bench for sideband_retimer: level, zero-stage and edge-mode instances.
module tb_sideband_retimer;

    logic       clock;
    logic       reset;
    logic [5:0] in_sig;
    logic [5:0] ack;

    logic [5:0] lvl_out, lvl_ovf;
    logic [5:0] s0_out,  s0_ovf;
    logic [5:0] edg_out, edg_ovf;

    int n_checks = 0;
    int n_err    = 0;

    sideband_retimer #(.CHANNELS(6), .STAGES(2), .EDGE_MASK(6'h00)) u_lvl (
        .clock(clock), .reset(reset), .in_sig(in_sig), .ack(ack),
        .out_sig(lvl_out), .overflow(lvl_ovf));

    sideband_retimer #(.CHANNELS(6), .STAGES(0), .EDGE_MASK(6'h00)) u_s0 (
        .clock(clock), .reset(reset), .in_sig(in_sig), .ack(ack),
        .out_sig(s0_out), .overflow(s0_ovf));

    sideband_retimer #(.CHANNELS(6), .STAGES(2), .EDGE_MASK(6'h01)) u_edg (
        .clock(clock), .reset(reset), .in_sig(in_sig), .ack(ack),
        .out_sig(edg_out), .overflow(edg_ovf));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [5:0] in_v;
        logic [5:0] ack_v;
        logic [5:0] exp_lvl;
        logic [5:0] exp_edg;
        logic [5:0] exp_ovf;
    } vec_t;

    vec_t vecs [28];

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_vec(input int idx, input logic [5:0] i, input logic [5:0] a,
                           input logic [5:0] l, input logic [5:0] e, input logic [5:0] o);
        vecs[idx].in_v    = i;
        vecs[idx].ack_v   = a;
        vecs[idx].exp_lvl = l;
        vecs[idx].exp_edg = e;
        vecs[idx].exp_ovf = o;
    endtask

    // Held-high-through-reset expectations for edge channel 0 (one event only).
    logic [5:0] hold_exp [8];
    logic [5:0] hold_ack [8];

    initial begin
        // Row outputs are sampled after the edge that consumes the row's inputs.
        set_vec( 0, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
        set_vec( 1, 6'h2A, 6'h00, 6'h00, 6'h00, 6'h00);
        set_vec( 2, 6'h2A, 6'h00, 6'h2A, 6'h2A, 6'h00);
        set_vec( 3, 6'h15, 6'h00, 6'h2A, 6'h2A, 6'h00);
        set_vec( 4, 6'h00, 6'h00, 6'h15, 6'h14, 6'h00);
        set_vec( 5, 6'h00, 6'h00, 6'h00, 6'h01, 6'h00);
        set_vec( 6, 6'h00, 6'h00, 6'h00, 6'h01, 6'h00);
        set_vec( 7, 6'h00, 6'h3F, 6'h00, 6'h00, 6'h00);
        set_vec( 8, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
        set_vec( 9, 6'h01, 6'h00, 6'h00, 6'h00, 6'h00);
        set_vec(10, 6'h00, 6'h00, 6'h01, 6'h00, 6'h00);
        set_vec(11, 6'h01, 6'h00, 6'h00, 6'h01, 6'h00);
        set_vec(12, 6'h00, 6'h00, 6'h01, 6'h01, 6'h00);
        set_vec(13, 6'h00, 6'h00, 6'h00, 6'h01, 6'h01);
        set_vec(14, 6'h00, 6'h01, 6'h00, 6'h00, 6'h00);
        set_vec(15, 6'h01, 6'h00, 6'h00, 6'h00, 6'h00);
        set_vec(16, 6'h00, 6'h00, 6'h01, 6'h00, 6'h00);
        set_vec(17, 6'h00, 6'h01, 6'h00, 6'h01, 6'h00);
        set_vec(18, 6'h00, 6'h00, 6'h00, 6'h01, 6'h00);
        set_vec(19, 6'h00, 6'h01, 6'h00, 6'h00, 6'h00);
        set_vec(20, 6'h00, 6'h01, 6'h00, 6'h00, 6'h00);
        set_vec(21, 6'h01, 6'h00, 6'h00, 6'h00, 6'h00);
        set_vec(22, 6'h01, 6'h00, 6'h01, 6'h00, 6'h00);
        set_vec(23, 6'h01, 6'h00, 6'h01, 6'h01, 6'h00);
        set_vec(24, 6'h01, 6'h01, 6'h01, 6'h00, 6'h00);
        set_vec(25, 6'h01, 6'h00, 6'h01, 6'h00, 6'h00);
        set_vec(26, 6'h00, 6'h00, 6'h01, 6'h00, 6'h00);
        set_vec(27, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);

        hold_exp[0] = 6'h00; hold_ack[0] = 6'h00;
        hold_exp[1] = 6'h00; hold_ack[1] = 6'h00;
        hold_exp[2] = 6'h01; hold_ack[2] = 6'h00;
        hold_exp[3] = 6'h00; hold_ack[3] = 6'h01;
        hold_exp[4] = 6'h00; hold_ack[4] = 6'h00;
        hold_exp[5] = 6'h00; hold_ack[5] = 6'h00;
        hold_exp[6] = 6'h00; hold_ack[6] = 6'h00;
        hold_exp[7] = 6'h00; hold_ack[7] = 6'h00;

        reset  = 1'b1;
        in_sig = 6'h00;
        ack    = 6'h00;
        step();
        step();
        check("reset lvl_out", lvl_out, 6'h00);
        check("reset edg_out", edg_out, 6'h00);
        check("reset edg_ovf", edg_ovf, 6'h00);
        reset = 1'b0;

        for (int r = 0; r < 28; r++) begin
            in_sig = vecs[r].in_v;
            ack    = vecs[r].ack_v;
            #1;
            check($sformatf("row%0d s0_out", r), s0_out, vecs[r].in_v);
            step();
            check($sformatf("row%0d lvl_out", r), lvl_out, vecs[r].exp_lvl);
            check($sformatf("row%0d lvl_ovf", r), lvl_ovf, 6'h00);
            check($sformatf("row%0d s0_ovf", r),  s0_ovf,  6'h00);
            check($sformatf("row%0d edg_out", r), edg_out, vecs[r].exp_edg);
            check($sformatf("row%0d edg_ovf", r), edg_ovf, vecs[r].exp_ovf);
        end

        // Input held high through reset: exactly one event after release.
        in_sig = 6'h01;
        ack    = 6'h00;
        reset  = 1'b1;
        #1;
        check("hold rst edg_out", edg_out, 6'h00);
        check("hold rst lvl_out", lvl_out, 6'h00);
        check("hold rst s0_out",  s0_out,  6'h01);
        step();
        reset = 1'b0;
        for (int s = 0; s < 8; s++) begin
            ack = hold_ack[s];
            step();
            check($sformatf("hold%0d edg_out", s), edg_out, hold_exp[s]);
        end
        ack = 6'h00;

        // Flush, then build pending + overflow, then reset mid-pipeline.
        in_sig = 6'h00;
        for (int s = 0; s < 4; s++) step();
        in_sig = 6'h01; step();
        in_sig = 6'h00; step();
        step();
        check("mid p1 edg_out", edg_out, 6'h01);
        in_sig = 6'h01; step();
        in_sig = 6'h00; step();
        step();
        check("mid p2 edg_out", edg_out, 6'h01);
        check("mid p2 edg_ovf", edg_ovf, 6'h01);
        in_sig = 6'h01; step();
        in_sig = 6'h00; step();
        check("mid pre lvl_out", lvl_out, 6'h01);
        #3;
        reset = 1'b1;
        #1;
        check("mid async edg_out", edg_out, 6'h00);
        check("mid async edg_ovf", edg_ovf, 6'h00);
        check("mid async lvl_out", lvl_out, 6'h00);
        step();
        reset = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step();
            check($sformatf("mid post%0d edg_out", s), edg_out, 6'h00);
            check($sformatf("mid post%0d edg_ovf", s), edg_ovf, 6'h00);
            check($sformatf("mid post%0d lvl_out", s), lvl_out, 6'h00);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
